// File: rtl/debounce_pulse_if.sv
// debounce_pulse_if: raw button level in, debounced level and press/release pulses out
interface debounce_pulse_if;
    logic btn;
    logic enable;
    logic rel;
    logic level;
    modport master (output btn, input enable, rel, level);
    modport slave (input btn, output enable, rel, level);
endinterface

// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronise and debounce a push-button, emitting one-cycle press/release pulses
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    debounce_pulse_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DISARM = 2'd3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic s1, btn_s, enable, rel;
    logic [1:0] state, nxt;
    logic [CNT_W-1:0] cnt, ncnt;

    always_comb begin
        nxt = state;
        ncnt = cnt;
        case (state)
            IDLE: if (btn_s) begin
                nxt = ARM;
                ncnt = '0;
            end
            ARM: if (!btn_s) nxt = IDLE;
            else if (cnt == LAST) nxt = HIGH;
            else ncnt = cnt + CNT_W'(1);
            HIGH: if (!btn_s) begin
                nxt = DISARM;
                ncnt = '0;
            end
            default: if (btn_s) nxt = HIGH;
            else if (cnt == LAST) nxt = IDLE;
            else ncnt = cnt + CNT_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            btn_s <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            enable <= 1'b0;
            rel <= 1'b0;
        end else begin
            s1 <= bus.btn;
            btn_s <= s1;
            state <= nxt;
            cnt <= ncnt;
            enable <= state == ARM && nxt == HIGH;
            rel <= state == DISARM && nxt == IDLE;
        end
    end

    // state encoding puts the debounced level in the top bit
    assign bus.level = state[1];
    assign bus.enable = enable;
    assign bus.rel = rel;
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed stimulus with a pulse scoreboard and a behavioural downstream toggle
module tb_debounce_pulse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q = 1'b0;
    logic exp_q = 1'b0;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit kind;
        int at;
    } ev_t;
    ev_t sb[$];

    debounce_pulse_if bus();
    debounce_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) q <= q ^ bus.enable;

    task automatic expect_ev(input bit kind, input int at);
        sb.push_back('{kind, at});
        if (!kind) exp_q = ~exp_q;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0b required %0b", name, cyc, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (bus.enable && bus.rel) begin
            compared++;
            mismatched++;
            $display("FAIL overlap at edge %0d: enable and rel both 1, required exclusive", cyc);
        end
        while (sb.size() > 0 && sb[0].at < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missed_%s: no pulse, required one after edge %0d", sb[0].kind ? "rel" : "enable", sb[0].at);
            void'(sb.pop_front());
        end
        if (bus.enable || bus.rel) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse at edge %0d: enable=%0b rel=%0b, required none", cyc, bus.enable, bus.rel);
            end else begin
                e = sb.pop_front();
                if (e.kind !== bus.rel || e.at != cyc) begin
                    mismatched++;
                    $display("FAIL pulse: got %s after edge %0d, required %s after edge %0d",
                             bus.rel ? "rel" : "enable", cyc, e.kind ? "rel" : "enable", e.at);
                end
            end
        end
    end

    initial begin
        int k;
        bus.btn = 1'b1;
        ticks(2);
        chk("reset_level", bus.level, 1'b0);
        chk("reset_enable", bus.enable, 1'b0);
        chk("reset_rel", bus.rel, 1'b0);
        rst = 1'b0;
        expect_ev(1'b0, cyc + 7);
        ticks(12);
        chk("held_after_reset_level", bus.level, 1'b1);
        bus.btn = 1'b0;
        expect_ev(1'b1, cyc + 7);
        ticks(12);
        chk("release_level", bus.level, 1'b0);
        chk("q_after_first", q, exp_q);

        bus.btn = 1'b1;
        k = cyc + 1;
        expect_ev(1'b0, k + 6);
        expect_ev(1'b1, k + 16);
        ticks(8);
        chk("clean_level_high", bus.level, 1'b1);
        ticks(2);
        bus.btn = 1'b0;
        ticks(5);
        chk("clean_level_before_rel", bus.level, 1'b1);
        ticks(3);
        chk("clean_level_low", bus.level, 1'b0);
        chk("clean_q", q, exp_q);

        bus.btn = 1'b1;
        ticks(3);
        bus.btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            chk("glitch_level", bus.level, 1'b0);
        end
        chk("glitch_q", q, exp_q);

        for (int i = 0; i < 5; i++) begin
            bus.btn = (i % 2) == 0;
            if (i == 4) expect_ev(1'b0, cyc + 7);
            ticks(1);
        end
        ticks(14);
        chk("bounce_level", bus.level, 1'b1);
        chk("bounce_q", q, exp_q);

        bus.btn = 1'b0;
        expect_ev(1'b1, cyc + 9);
        ticks(1);
        bus.btn = 1'b1;
        ticks(1);
        bus.btn = 1'b0;
        ticks(5);
        chk("bouncy_rel_level_hold", bus.level, 1'b1);
        ticks(4);
        chk("bouncy_rel_level_low", bus.level, 1'b0);

        bus.btn = 1'b1;
        ticks(4);
        rst = 1'b1;
        ticks(1);
        chk("rst_arm_enable", bus.enable, 1'b0);
        chk("rst_arm_level", bus.level, 1'b0);
        chk("rst_arm_rel", bus.rel, 1'b0);
        rst = 1'b0;
        expect_ev(1'b0, cyc + 7);
        ticks(10);
        chk("rst_arm_repress_level", bus.level, 1'b1);

        rst = 1'b1;
        ticks(1);
        chk("rst_high_level", bus.level, 1'b0);
        chk("rst_high_rel", bus.rel, 1'b0);
        rst = 1'b0;
        expect_ev(1'b0, cyc + 7);
        ticks(10);
        chk("rst_high_repress_level", bus.level, 1'b1);
        bus.btn = 1'b0;
        expect_ev(1'b1, cyc + 7);
        ticks(10);
        chk("final_level", bus.level, 1'b0);
        chk("final_q", q, exp_q);

        ticks(2);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL pending_events: got %0d outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Upstream conditioning stage for the T flip-flop with enable (`FFT`). It takes a raw, bouncing push-button level and synchronises it to `clk`. It debounces the level with a counter-based state machine. Its `enable` output is a clean single-cycle pulse per accepted press, wired directly to `FFT`'s `enable`, so one physical press toggles `q` exactly once.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of extra consecutive stable samples required to accept a level change. Legal range is 1 to 2^CNT_W − 1.
- `CNT_W`, default 16: width of the internal debounce counter.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset. It is sampled on the `clk` rising edge and overrides all other activity.
- `btn`, input, 1: raw asynchronous button level, 1 = pressed.
- `enable`, output, 1: one-cycle pulse on each accepted press; drives `FFT.enable`.
- `rel`, output, 1: one-cycle pulse on each accepted release.
- `level`, output, 1: debounced button level.

## Operation
- Synchroniser: two-flop chain `btn` → `s1` → `btn_s`. The FSM consumes only `btn_s`.
- FSM has four states, with counter `cnt[CNT_W-1:0]`. Let N = `DEBOUNCE_CYCLES`.
  - IDLE (`level`=0):
    - `btn_s`=1 → ARM, `cnt`←0.
    - Otherwise stay in IDLE.
  - ARM (`level`=0):
    - `btn_s`=0 → IDLE.
    - `btn_s`=1 and `cnt`=N−1 → HIGH.
    - Otherwise `cnt`←`cnt`+1.
  - HIGH (`level`=1):
    - `btn_s`=0 → DISARM, `cnt`←0.
    - Otherwise stay in HIGH.
  - DISARM (`level`=1):
    - `btn_s`=1 → HIGH, with no pulse.
    - `btn_s`=0 and `cnt`=N−1 → IDLE.
    - Otherwise `cnt`←`cnt`+1.
- Acceptance rule: a press is accepted only when `btn_s` is sampled 1 on N+1 consecutive edges, starting with the edge that leaves IDLE. Release is symmetric.
- Any contrary sample in ARM or DISARM aborts and returns to the previous stable state. The counter restarts from 0 on the next entry.
- `enable` is registered. It is set on the edge taking ARM → HIGH and cleared on the following edge. `rel` behaves the same for DISARM → IDLE.
- `level` is registered and equals 1 exactly in HIGH and DISARM.
- `enable` and `rel` are never high in the same cycle.
- A button held for any duration gives exactly one `enable`. There is no auto-repeat.
- Counter never wraps: it saturates in practice because N−1 < 2^CNT_W.

## Timing
- Reset: on any edge with `rst`=1, the following are all cleared:
  - state → IDLE, `cnt`←0
  - `s1`←0, `btn_s`←0
  - `enable`←0, `rel`←0, `level`←0
- Reset mid-operation:
  - In ARM or DISARM, any pending transition is discarded and no pulse is emitted.
  - In HIGH, `level` drops to 0 with no `rel`.
- After `rst` deasserts, a button still held is treated as a new press and yields one `enable` after the full latency.
- Press latency: `btn` first sampled 1 at edge k.
  - `btn_s`=1 after edge k+1.
  - ARM entered at edge k+2.
  - HIGH, `level`=1 and `enable`=1 after edge k+2+N.
  - `enable` falls after edge k+3+N.
  - For N=4, `enable` is high during the cycle following edge k+6.
- Release latency is identical, measured from the first 0 sample, with `rel` in place of `enable`.
- Minimum accepted pulse: `btn` stable for N+1 consecutive sampling edges; anything shorter is rejected.
- Downstream `FFT` sees `enable` for exactly one rising edge and toggles `q` once.

## Test plan
Common setup: clock period 10 ns, N=4, `FFT` instantiated downstream.
- Reset: `rst`=1 for 1 edge while `btn`=1 → next cycle `level`=0, `enable`=0, `rel`=0. After release of `rst`, with `btn` held, `enable` pulses once 6 edges later.
- Clean press held 100 ns → exactly one `enable` pulse, 1 cycle wide, 6 edges after the first sample. `level`=1 until release. `FFT.q` toggles 0→1 once.
- Glitch: `btn`=1 for 3 cycles, then 0 → `enable` never asserts, `level` stays 0, `FFT.q` unchanged.
- Bounce: `btn` = 1,0,1,0,1 on successive cycles, then held 1 → exactly one `enable`, occurring 6 edges after the final rising sample.
- Bouncy release: from HIGH, `btn` = 0,1,0 on successive cycles, then held 0 → no `enable`, exactly one `rel`, then `level`=0.
- Reset mid-ARM: assert `rst` 2 edges after ARM entry with `btn`=1 → no `enable` that cycle, outputs 0. With `btn` still held, `enable` fires 6 edges after reset release.
